// File: rtl/photo_ctrl_pkg.sv
// Shared types for the photo capture controller: FSM encoding, index/count widths
// and slot-index wrap helpers.
package photo_ctrl_pkg;

  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_VIEW    = 2'd3
  } state_t;

  function automatic logic [IDX_W-1:0] idx_inc_wrap(input logic [IDX_W-1:0] idx,
                                                    input logic [IDX_W-1:0] last);
    return (idx == last) ? '0 : idx + 1'b1;
  endfunction

  function automatic logic [IDX_W-1:0] idx_dec_wrap(input logic [IDX_W-1:0] idx,
                                                    input logic [IDX_W-1:0] last);
    return (idx == '0) ? last : idx - 1'b1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low key -> 2-flop synchroniser -> stability counter -> one-cycle
// pulse on the accepted high-to-low transition.
module key_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic key_n,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  logic          sync1, sync2, stable;
  logic [CW-1:0] cnt;

  // Synchroniser and accepted level reset to the released (high) level so that
  // leaving reset never looks like a press.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes sync1 -> sync2 a real two-stage synchroniser.
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
        cnt    <= '0;
        stable <= sync2;
        press  <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/photo_capture_ctrl.sv
// Capture/view controller for the SRAM frame saver: debounced keys drive an
// IDLE/ARM/RELEASE/VIEW FSM. Define CAPTURE_AUTO_VIEW_EN to jump to VIEW after a capture.
module photo_capture_ctrl
  import photo_ctrl_pkg::*;
#(
  parameter int MAX_PHOTOS     = 8,
  parameter int DEBOUNCE_CYC   = 250000,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iKEY_CAP_N,
  input  logic             iKEY_VIEW_N,
  input  logic             iVGA_VSYNC_N,
  input  logic             iStore_finish,
  output logic             oTake_frame,
  output logic             oRead_Disp,
  output logic [IDX_W-1:0] oPhoto_Index,
  output logic [CNT_W-1:0] oPhoto_Count,
  output logic             oErr,
  output logic [1:0]       oState
);

  localparam int                VS_W      = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(MAX_PHOTOS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(MAX_PHOTOS);

  logic cap_press, view_press;

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_cap_db (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .key_n (iKEY_CAP_N),
    .press (cap_press)
  );

  key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_view_db (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .key_n (iKEY_VIEW_N),
    .press (view_press)
  );

  state_t           state, state_n;
  logic [IDX_W-1:0] wr_idx, wr_idx_n, view_idx, view_idx_n;
  logic [CNT_W-1:0] count, count_n;
  logic [VS_W-1:0]  vs_cnt, vs_cnt_n;
  logic             err, err_n, success, success_n, rel_cnt, rel_cnt_n;
  logic             vsync_q, vs_fall;

  assign vs_fall = vsync_q & ~iVGA_VSYNC_N;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= ST_IDLE;
      wr_idx   <= '0;
      view_idx <= '0;
      count    <= '0;
      vs_cnt   <= '0;
      err      <= 1'b0;
      success  <= 1'b0;
      rel_cnt  <= 1'b0;
      vsync_q  <= 1'b0;
    end else begin
      state    <= state_n;
      wr_idx   <= wr_idx_n;
      view_idx <= view_idx_n;
      count    <= count_n;
      vs_cnt   <= vs_cnt_n;
      err      <= err_n;
      success  <= success_n;
      rel_cnt  <= rel_cnt_n;
      vsync_q  <= iVGA_VSYNC_N;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_n    = state;
    wr_idx_n   = wr_idx;
    view_idx_n = view_idx;
    count_n    = count;
    vs_cnt_n   = vs_cnt;
    err_n      = err;
    success_n  = success;
    rel_cnt_n  = rel_cnt;

    unique case (state)
      ST_IDLE: begin
        // Capture wins when both keys fire in the same cycle.
        if (cap_press) begin
          state_n  = ST_ARM;
          vs_cnt_n = '0;
        end else if (view_press && count != '0) begin
          state_n    = ST_VIEW;
          view_idx_n = idx_dec_wrap(wr_idx, LAST_SLOT);
        end
      end

      ST_ARM: begin
        if (iStore_finish) begin
          state_n   = ST_RELEASE;
          success_n = 1'b1;
          err_n     = 1'b0;
          rel_cnt_n = 1'b0;
        end else if (vs_fall) begin
          if (vs_cnt == VS_W'(TIMEOUT_FRAMES - 1)) begin
            state_n   = ST_RELEASE;
            success_n = 1'b0;
            err_n     = 1'b1;
            rel_cnt_n = 1'b0;
          end else begin
            vs_cnt_n = vs_cnt + 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        // rel_cnt guarantees at least two cycles here even if the flag is already low.
        rel_cnt_n = 1'b1;
        if (!iStore_finish && rel_cnt) begin
          state_n = ST_IDLE;
          if (success) begin
            wr_idx_n = idx_inc_wrap(wr_idx, LAST_SLOT);
            count_n  = (count == FULL_CNT) ? count : count + 1'b1;
`ifdef CAPTURE_AUTO_VIEW_EN
            state_n    = ST_VIEW;
            view_idx_n = wr_idx;
`endif
          end
        end
      end

      ST_VIEW: begin
        if (cap_press) begin
          state_n = ST_IDLE;
        end else if (view_press) begin
          view_idx_n = idx_inc_wrap(view_idx, IDX_W'(count - 1'b1));
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign oTake_frame  = (state == ST_ARM);
  assign oRead_Disp   = (state == ST_VIEW);
  assign oPhoto_Index = (state == ST_VIEW) ? view_idx : wr_idx;
  assign oPhoto_Count = count;
  assign oErr         = err;
  assign oState       = state;

endmodule

// File: tb/tb_photo_capture_ctrl.sv
// Scoreboard bench for photo_capture_ctrl: stimulus queues expected snapshots,
// a monitor compares on every state change or explicit sample request.
module tb_photo_capture_ctrl;
  import photo_ctrl_pkg::*;

  localparam int DEB  = 8;
  localparam int MAXP = 8;
  localparam int TMO  = 4;
  localparam int HOLD = DEB + 8;

  logic       iCLK = 1'b0;
  logic       iRST_N = 1'b0;
  logic       cap_n = 1'b1, view_n = 1'b1, vsync_n = 1'b1, store_finish = 1'b0;
  logic       take, disp, err;
  logic [3:0] idx;
  logic [4:0] cnt;
  logic [1:0] st;

  photo_capture_ctrl #(.MAX_PHOTOS(MAXP), .DEBOUNCE_CYC(DEB), .TIMEOUT_FRAMES(TMO)) dut (
    .iCLK         (iCLK),
    .iRST_N       (iRST_N),
    .iKEY_CAP_N   (cap_n),
    .iKEY_VIEW_N  (view_n),
    .iVGA_VSYNC_N (vsync_n),
    .iStore_finish(store_finish),
    .oTake_frame  (take),
    .oRead_Disp   (disp),
    .oPhoto_Index (idx),
    .oPhoto_Count (cnt),
    .oErr         (err),
    .oState       (st)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [1:0] st;
    logic       take;
    logic       disp;
    logic [3:0] idx;
    logic [4:0] cnt;
    logic       err;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0, errors = 0;
  int    sample_cnt = 0;
  bit    done = 1'b0;
  int    m_wr = 0, m_cnt = 0;
  bit    m_err = 1'b0;

  task automatic expect_snap(input state_t s, input bit t, input bit d,
                             input int i, input int c, input bit e);
    snap_t x;
    x.st = s; x.take = t; x.disp = d; x.idx = 4'(i); x.cnt = 5'(c); x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic press(input bit c, input bit v);
    if (c) cap_n = 1'b0;
    if (v) view_n = 1'b0;
    cyc(HOLD);
    cap_n = 1'b1; view_n = 1'b1;
    cyc(HOLD);
  endtask

  task automatic vs_fall();
    vsync_n = 1'b0; cyc(3);
    vsync_n = 1'b1; cyc(3);
  endtask

  task automatic sample();
    sample_cnt++;
    cyc(1);
  endtask

  task automatic capture_ok(input int nvs, input bit both, input bit view_in_arm);
    expect_snap(ST_ARM, 1, 0, m_wr, m_cnt, m_err);
    press(1, both);
    if (view_in_arm) press(0, 1);
    repeat (nvs) vs_fall();
    expect_snap(ST_RELEASE, 0, 0, m_wr, m_cnt, 0);
    m_err = 1'b0;
    m_wr  = (m_wr + 1) % MAXP;
    if (m_cnt < MAXP) m_cnt++;
    expect_snap(ST_IDLE, 0, 0, m_wr, m_cnt, 0);
    store_finish = 1'b1; cyc(4);
    store_finish = 1'b0; cyc(4);
  endtask

  task automatic capture_timeout();
    expect_snap(ST_ARM, 1, 0, m_wr, m_cnt, m_err);
    press(1, 0);
    expect_snap(ST_RELEASE, 0, 0, m_wr, m_cnt, 1);
    m_err = 1'b1;
    expect_snap(ST_IDLE, 0, 0, m_wr, m_cnt, 1);
    repeat (TMO) vs_fall();
    cyc(4);
  endtask

  task automatic check(input snap_t a, input snap_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL snapshot_%0d: got st=%0d take=%0b disp=%0b idx=%0d cnt=%0d err=%0b, want st=%0d take=%0b disp=%0b idx=%0d cnt=%0d err=%0b",
               checks, a.st, a.take, a.disp, a.idx, a.cnt, a.err,
               e.st, e.take, e.disp, e.idx, e.cnt, e.err);
    end
  endtask

  // Monitor: one scoreboard pop per observed state change or sample request.
  initial begin
    logic [1:0] prev;
    int         seen;
    snap_t      a;
    prev = 2'd0;
    seen = 0;
    while (!done) begin
      @(negedge iCLK or sample_cnt or done);
      if (done) break;
      if (sample_cnt != seen || st !== prev) begin
        seen = sample_cnt;
        prev = st;
        a.st = st; a.take = take; a.disp = disp; a.idx = idx; a.cnt = cnt; a.err = err;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_change: got st=%0d idx=%0d cnt=%0d, want no change", st, idx, cnt);
        end else begin
          check(a, exp_q.pop_front());
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d expected events unobserved, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    // Reset state.
    expect_snap(ST_IDLE, 0, 0, 0, 0, 0);
    cyc(2);
    sample();
    iRST_N = 1'b1;
    cyc(5);

    // First capture: three VSYNC falls, then store finishes.
    capture_ok(3, 0, 0);
    // Simultaneous keys count as capture; a view press in ARM is ignored.
    capture_ok(1, 1, 0);
    capture_ok(0, 0, 1);

    // View walk with three stored photos: 2,0,1,2, then capture key exits.
    expect_snap(ST_VIEW, 0, 1, 2, 3, 0);
    press(0, 1);
    for (int i = 0; i < 3; i++) begin
      expect_snap(ST_VIEW, 0, 1, i, 3, 0);
      press(0, 1);
      sample();
    end
    expect_snap(ST_IDLE, 0, 0, m_wr, m_cnt, m_err);
    press(1, 0);

    // Glitch shorter than the debounce window.
    cap_n = 1'b0; cyc(DEB / 2);
    cap_n = 1'b1; cyc(3 * HOLD);
    expect_snap(ST_IDLE, 0, 0, m_wr, m_cnt, m_err);
    sample();

    // Timeout leaves count and index alone, sets the sticky error.
    capture_timeout();

    // Six more successes: wrap to slot 0 and saturate at MAX_PHOTOS.
    for (int i = 0; i < 6; i++) capture_ok(2, 0, 0);

    // Reset in the middle of ARM.
    expect_snap(ST_ARM, 1, 0, m_wr, m_cnt, m_err);
    press(1, 0);
    expect_snap(ST_IDLE, 0, 0, 0, 0, 0);
    iRST_N = 1'b0;
    #1 sample_cnt++;
    cyc(2);
    iRST_N = 1'b1;
    m_wr = 0; m_cnt = 0; m_err = 1'b0;
    cyc(5);
    capture_ok(1, 0, 0);

    cyc(5);
    done = 1'b1;
  end

endmodule

// File: doc/photo_capture_ctrl.md
PHOTO_CAPTURE_CTRL -- requirements
Module: photo_capture_ctrl

Interface
REQ-001 Parameter MAX_PHOTOS, default 8, number of SRAM photo slots, legal range 1..16.
REQ-002 Parameter DEBOUNCE_CYC, default 250000, iCLK cycles a key level must stay stable before it is accepted.
REQ-003 Parameter TIMEOUT_FRAMES, default 4, VSYNC falling edges allowed for a capture to finish.
REQ-004 iCLK  in  1  pixel clock, the same clock as the frame saver.
REQ-005 iRST_N  in  1  reset, asynchronous, active-low.
REQ-006 iKEY_CAP_N  in  1  capture key, active-low, raw and unsynchronised.
REQ-007 iKEY_VIEW_N  in  1  view/next key, active-low, raw and unsynchronised.
REQ-008 iVGA_VSYNC_N  in  1  VGA vertical sync.
REQ-009 iStore_finish  in  1  frame-stored flag from the saver.
REQ-010 oTake_frame  out  1  capture request to the saver.
REQ-011 oRead_Disp  out  1  tells the saver to drive VGA from SRAM.
REQ-012 oPhoto_Index  out  4  slot index to the saver.
REQ-013 oPhoto_Count  out  5  number of valid stored photos.
REQ-014 oErr  out  1  sticky capture-timeout flag.
REQ-015 oState  out  2  FSM state, for debug.

Function
REQ-016 Each key SHALL pass through a 2-flop synchroniser and then a debouncer; a press event SHALL be a one-cycle pulse on the debounced high-to-low transition.
REQ-017 The FSM SHALL have states IDLE=0, ARM=1, RELEASE=2 and VIEW=3.
REQ-018 IDLE: on a capture press go to ARM; else on a view press with count>0 go to VIEW with view_idx set to the last written slot; else stay in IDLE.
REQ-019 ARM: oTake_frame=1 and oPhoto_Index=wr_idx held constant; when iStore_finish is seen high, go to RELEASE with a success mark.
REQ-020 ARM: count VSYNC falling edges; when the count reaches TIMEOUT_FRAMES with iStore_finish low, set oErr and go to RELEASE with no success mark.
REQ-021 RELEASE: oTake_frame=0; wait for iStore_finish low, or at least 2 cycles if it is already low, then act on the mark.
REQ-022 RELEASE on success: wr_idx advances with wrap (MAX_PHOTOS-1 to 0); oPhoto_Count increments and saturates at MAX_PHOTOS.
REQ-023 RELEASE on timeout: wr_idx and the count stay unchanged.
REQ-024 VIEW: oRead_Disp=1 and oPhoto_Index=view_idx.
REQ-025 VIEW: a view press steps view_idx to the next valid slot, wrapping at oPhoto_Count-1 to 0.
REQ-026 VIEW: a capture press returns to IDLE and does not capture.
REQ-027 A press on either key SHALL be ignored in ARM and RELEASE.
REQ-028 A simultaneous capture press and view press SHALL be treated as a capture press only.
REQ-029 oPhoto_Index SHALL equal wr_idx in IDLE, ARM and RELEASE.
REQ-030 oErr SHALL clear on the next successful capture.

Reset
REQ-031 Asynchronous reset SHALL set state=IDLE and zero every output, wr_idx, view_idx, the VSYNC counter and the debouncer counters.
REQ-032 Reset mid-ARM SHALL drop oTake_frame to 0 in the same instant and leave no slot counted.

Configuration
REQ-033 With CAPTURE_AUTO_VIEW_EN defined, a successful RELEASE SHALL go to VIEW with view_idx set to the slot just written.
REQ-034 Without CAPTURE_AUTO_VIEW_EN, RELEASE SHALL always return to IDLE.
REQ-035 With or without CAPTURE_AUTO_VIEW_EN, a timeout RELEASE SHALL return to IDLE.

Structure
REQ-036 The shared package photo_ctrl_pkg SHALL hold the state encodings, the index width (4) and the count width (5).
REQ-037 The sub-module key_debounce (synchroniser, stability counter, fall-edge pulse) SHALL be instantiated twice.

Verification
REQ-038 Reset, then a capture press, then iStore_finish high 3 VSYNCs later -> oTake_frame high during ARM with oPhoto_Index=0; afterwards count=1 and wr_idx=1.
REQ-039 Nine captures with MAX_PHOTOS=8 -> the ninth uses oPhoto_Index=0 and count saturates at 8.
REQ-040 Capture with iStore_finish held low for 4 VSYNC falls -> oErr=1, count unchanged, state returns to IDLE.
REQ-041 Count=3, then a view press, then 3 more view presses -> oRead_Disp=1 and the index sequence 2,0,1,2.
REQ-042 A key glitch shorter than DEBOUNCE_CYC -> no state change.
REQ-043 Assert reset during ARM -> oTake_frame=0 immediately and count=0.
